mano_timing_control: RTL and testbench
======================================

Name: mano_timing_control

Overview:
- Produces the timing and decode signals consumed by the per-register control equations (PC, AR, AC, ...).
- Contains:
  - sequence counter SC, decoded to one-hot timing vector t;
  - instruction register IR, loaded at T1;
  - opcode decoder producing one-hot d;
  - indirect flip-flop I;
  - start/stop flip-flop S.
- Sits between the memory/bus and the control-logic blocks. Those blocks drive its sc_clr input at the end of each instruction.

Parameters:
- SC_WIDTH, 3, sequence counter width; t width is 2**SC_WIDTH (default 8, T0..T7).
- IR_WIDTH, 16, instruction word width; opcode = ir[IR_WIDTH-2:IR_WIDTH-4], I = ir[IR_WIDTH-1].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; sets S.
- halt  input  1  one-cycle pulse from the HLT control term; clears S.
- sc_clr  input  1  end-of-instruction clear from control logic.
- ir_in  input  IR_WIDTH  instruction word from the common bus / memory.
- t  output  2**SC_WIDTH  one-hot timing signals T0..Tn, gated by S.
- d  output  8  one-hot opcode decode D0..D7.
- i_bit  output  1  indirect flip-flop I.
- ir_q  output  IR_WIDTH  IR contents.
- sc_q  output  SC_WIDTH  raw SC value.
- running  output  1  S flip-flop.
- err_wrap  output  1  sticky; SC wrapped from max to 0 without sc_clr.

Behaviour:
- Reset (asynchronous, any time including mid-instruction) sets:
  - SC=0, S=0, IR=0, I=0, err_wrap=0;
  - therefore t=0 (gated), d=8'b0000_0001 (IR=0 decodes to D0), i_bit=0, running=0.
- t:
  - t[k] = running & (sc_q==k), combinational from registers.
  - Exactly one bit is high when running=1; all bits are zero when running=0.
- d: combinational one-hot decode of ir_q[IR_WIDTH-2:IR_WIDTH-4]. Always exactly one bit high.
- S flip-flop, per edge, priority halt > start:
  - halt=1: S<=0 and SC<=0, so execution restarts at T0. IR, I and err_wrap are held.
  - halt=0, start=1: S<=1. SC is unchanged (it is 0 after reset or halt).
  - start while running: no effect.
- SC, when S=1 and halt=0, per edge:
  - sc_clr=1: SC<=0. Clear wins over increment.
  - otherwise: SC<=SC+1, modulo 2**SC_WIDTH.
  - If SC==max and sc_clr=0, SC wraps to 0 and err_wrap<=1 (sticky until rst).
- SC when S=0: frozen. sc_clr is ignored.
- IR:
  - IR<=ir_in on the edge ending T1 (t[1]=1). Otherwise held.
  - The new d is valid from T2 onward.
- I: i_bit<=ir_q[IR_WIDTH-1] on the edge ending T2. Otherwise held.
- Latency:
  - start pulse at edge n gives T0 visible after edge n.
  - Fetch sequence: T0 → T1 → T2 → T3 on consecutive cycles unless sc_clr is asserted.
- Simultaneous sc_clr and halt: halt wins. Result is SC=0, S=0.
- No combinational path from ir_in to any output.

Decomposition:
- Shared package (mano_pkg) holds:
  - the opcode constants OP_AND..OP_IO (0..7);
  - the IR field positions (opcode MSB/LSB, I bit);
  - localparam T_COUNT = 2**SC_WIDTH.
- One natural sub-module: mano_onehot_decoder (parameterised N-to-2**N). Instantiate it twice: SC→t (before gating) and opcode→d.
- SC, S, IR, I and err_wrap live in the top module.

Test Plan:
- Reset then idle: rst high 2 cycles, low 5 cycles, no start → t=0, d=8'h01, running=0, sc_q=0 throughout.
- Fetch/decode: start pulse; ir_in=16'h9234 during T1 → t walks 01,02,04,08; ir_q=16'h9234 after T1; d=8'h02 (opcode 1) from T2; i_bit=1 after T2.
- End-of-instruction: assert sc_clr during T4 → next cycle t=8'h01. Also assert sc_clr and the increment condition together → sc_q=0, no err_wrap.
- Wrap: run 8 cycles with no sc_clr → at T7 the next edge gives sc_q=0 and err_wrap=1. err_wrap stays 1 after a later sc_clr; it clears only on rst.
- Halt/start priority: halt at T3 → running=0, t=0, sc_q=0, IR held. Then start and halt on the same cycle → running stays 0. Then start alone → t=8'h01 the next cycle.
- Async reset mid-instruction: assert rst between edges at T5 → all outputs return to reset values immediately, with no clock edge needed.

Source files
------------

// File: rtl/mano_pkg.sv
// Shared constants for the Mano basic-computer timing and control slice.
package mano_pkg;

    localparam int unsigned SC_WIDTH_DEFAULT = 3;
    localparam int unsigned IR_WIDTH_DEFAULT = 16;
    localparam int unsigned T_COUNT          = 2 ** SC_WIDTH_DEFAULT;
    localparam int unsigned OP_WIDTH         = 3;

    localparam logic [OP_WIDTH-1:0] OP_AND = 3'd0;
    localparam logic [OP_WIDTH-1:0] OP_ADD = 3'd1;
    localparam logic [OP_WIDTH-1:0] OP_LDA = 3'd2;
    localparam logic [OP_WIDTH-1:0] OP_STA = 3'd3;
    localparam logic [OP_WIDTH-1:0] OP_BUN = 3'd4;
    localparam logic [OP_WIDTH-1:0] OP_BSA = 3'd5;
    localparam logic [OP_WIDTH-1:0] OP_ISZ = 3'd6;
    localparam logic [OP_WIDTH-1:0] OP_IO  = 3'd7;

    // Field positions are relative to the instruction word width.
    function automatic int unsigned ir_i_bit(input int unsigned ir_width);
        return ir_width - 1;
    endfunction

    function automatic int unsigned ir_op_msb(input int unsigned ir_width);
        return ir_width - 2;
    endfunction

    function automatic int unsigned ir_op_lsb(input int unsigned ir_width);
        return ir_width - 4;
    endfunction

endpackage

// File: rtl/mano_onehot_decoder.sv
// Binary-to-one-hot decoder, N select bits to 2**N outputs.
module mano_onehot_decoder #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0]      sel,
    output logic [2**N-1:0]   onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/mano_timing_control.sv
// Sequence counter, IR, I and S flip-flops with timing/opcode decode for the
// Mano basic computer control unit.
module mano_timing_control
    import mano_pkg::*;
#(
    parameter int unsigned SC_WIDTH = SC_WIDTH_DEFAULT,
    parameter int unsigned IR_WIDTH = IR_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   halt,
    input  logic                   sc_clr,
    input  logic [IR_WIDTH-1:0]    ir_in,
    output logic [2**SC_WIDTH-1:0] t,
    output logic [7:0]             d,
    output logic                   i_bit,
    output logic [IR_WIDTH-1:0]    ir_q,
    output logic [SC_WIDTH-1:0]    sc_q,
    output logic                   running,
    output logic                   err_wrap
);

    localparam int unsigned IBit  = ir_i_bit(IR_WIDTH);
    localparam int unsigned OpMsb = ir_op_msb(IR_WIDTH);
    localparam int unsigned OpLsb = ir_op_lsb(IR_WIDTH);

    logic [2**SC_WIDTH-1:0] t_raw;
    logic [OP_WIDTH-1:0]    opcode;

    assign opcode = ir_q[OpMsb:OpLsb];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc_q     <= '0;
            running  <= 1'b0;
            ir_q     <= '0;
            i_bit    <= 1'b0;
            err_wrap <= 1'b0;
        end else if (halt) begin
            // Halt restarts at T0 but preserves IR, I and the wrap flag.
            running <= 1'b0;
            sc_q    <= '0;
        end else begin
            if (start) begin
                running <= 1'b1;
            end
            if (running) begin
                if (sc_clr) begin
                    sc_q <= '0;
                end else begin
                    sc_q <= sc_q + 1'b1;
                    if (&sc_q) begin
                        err_wrap <= 1'b1;
                    end
                end
            end
            if (t[1]) begin
                ir_q <= ir_in;
            end
            if (t[2]) begin
                i_bit <= ir_q[IBit];
            end
        end
    end

    mano_onehot_decoder #(
        .N (SC_WIDTH)
    ) u_sc_decoder (
        .sel    (sc_q),
        .onehot (t_raw)
    );

    mano_onehot_decoder #(
        .N (OP_WIDTH)
    ) u_op_decoder (
        .sel    (opcode),
        .onehot (d)
    );

    assign t = running ? t_raw : '0;

endmodule

// File: tb/tb_mano_timing_control.sv
// Randomized and directed bench for mano_timing_control against a behavioural model.
module tb_mano_timing_control;
    import mano_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic        halt;
    logic        sc_clr;
    logic [15:0] ir_in;
    logic [7:0]  t;
    logic [7:0]  d;
    logic        i_bit;
    logic [15:0] ir_q;
    logic [2:0]  sc_q;
    logic        running;
    logic        err_wrap;

    int n_checks;
    int n_errors;

    // Behavioural model state
    int          m_sc;
    bit          m_run;
    logic [15:0] m_ir;
    bit          m_i;
    bit          m_err;

    mano_timing_control #(
        .SC_WIDTH (3),
        .IR_WIDTH (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .halt     (halt),
        .sc_clr   (sc_clr),
        .ir_in    (ir_in),
        .t        (t),
        .d        (d),
        .i_bit    (i_bit),
        .ir_q     (ir_q),
        .sc_q     (sc_q),
        .running  (running),
        .err_wrap (err_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sc  = 0;
        m_run = 0;
        m_ir  = '0;
        m_i   = 0;
        m_err = 0;
    endtask

    task automatic check_all(input string phase);
        logic [31:0] exp_t;
        logic [31:0] exp_d;
        exp_t = m_run ? (32'd1 << m_sc) : 32'd0;
        exp_d = 32'd1 << ((m_ir >> 12) & 16'd7);
        check_eq({phase, ".t"},        {24'd0, t},        exp_t);
        check_eq({phase, ".d"},        {24'd0, d},        exp_d);
        check_eq({phase, ".i_bit"},    {31'd0, i_bit},    {31'd0, m_i});
        check_eq({phase, ".ir_q"},     {16'd0, ir_q},     {16'd0, m_ir});
        check_eq({phase, ".sc_q"},     {29'd0, sc_q},     m_sc);
        check_eq({phase, ".running"},  {31'd0, running},  {31'd0, m_run});
        check_eq({phase, ".err_wrap"}, {31'd0, err_wrap}, {31'd0, m_err});
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic cycle(input string phase, input bit st, input bit hl, input bit clr,
                         input logic [15:0] word);
        int          n_sc;
        bit          n_run;
        logic [15:0] n_ir;
        bit          n_i;
        bit          n_err;
        start  = st;
        halt   = hl;
        sc_clr = clr;
        ir_in  = word;
        n_sc  = m_sc;
        n_run = m_run;
        n_ir  = m_ir;
        n_i   = m_i;
        n_err = m_err;
        if (hl) begin
            n_run = 0;
            n_sc  = 0;
        end else begin
            if (st) n_run = 1;
            if (m_run) begin
                if (clr) begin
                    n_sc = 0;
                end else begin
                    if (m_sc == T_COUNT - 1) n_err = 1;
                    n_sc = (m_sc + 1) % T_COUNT;
                end
                if (m_sc == 1) n_ir = word;
                if (m_sc == 2) n_i = m_ir[15];
            end
        end
        @(posedge clk);
        #1;
        m_sc  = n_sc;
        m_run = n_run;
        m_ir  = n_ir;
        m_i   = n_i;
        m_err = n_err;
        check_all(phase);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        start    = 1'b0;
        halt     = 1'b0;
        sc_clr   = 1'b0;
        ir_in    = '0;
        rst      = 1'b1;
        model_reset();

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        check_eq("reset.d_lit", {24'd0, d}, 32'h01);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) cycle("idle", 0, 0, 0, 16'hFFFF);

        // Fetch/decode
        cycle("fetch_t0", 1, 0, 0, 16'h0000);
        check_eq("fetch_t0_lit", {24'd0, t}, 32'h01);
        cycle("fetch_t1", 0, 0, 0, 16'h0000);
        check_eq("fetch_t1_lit", {24'd0, t}, 32'h02);
        cycle("fetch_t2", 0, 0, 0, 16'h9234);
        check_eq("fetch_t2_lit", {24'd0, t}, 32'h04);
        check_eq("fetch_ir_lit", {16'd0, ir_q}, 32'h9234);
        check_eq("fetch_d_lit", {24'd0, d}, 32'h02);
        cycle("fetch_t3", 0, 0, 0, 16'h0000);
        check_eq("fetch_t3_lit", {24'd0, t}, 32'h08);
        check_eq("fetch_i_lit", {31'd0, i_bit}, 32'd1);

        // End-of-instruction clear at T4
        cycle("to_t4", 0, 0, 0, 16'h0000);
        cycle("clr_t4", 0, 0, 1, 16'h0000);
        check_eq("clr_t_lit", {24'd0, t}, 32'h01);
        check_eq("clr_err_lit", {31'd0, err_wrap}, 32'd0);

        // Wrap: T0 -> T7 then wrap
        for (int k = 0; k < 8; k++) cycle("wrap", 0, 0, 0, 16'h1111);
        check_eq("wrap_sc_lit", {29'd0, sc_q}, 32'd0);
        check_eq("wrap_err_lit", {31'd0, err_wrap}, 32'd1);
        cycle("wrap_clr", 0, 0, 1, 16'h0000);
        check_eq("wrap_sticky_lit", {31'd0, err_wrap}, 32'd1);

        // Halt at T3, then start+halt, then start
        for (int k = 0; k < 3; k++) cycle("to_t3", 0, 0, 0, 16'h0000);
        cycle("halt", 0, 1, 1, 16'h0000);
        check_eq("halt_run_lit", {31'd0, running}, 32'd0);
        check_eq("halt_t_lit", {24'd0, t}, 32'h00);
        cycle("start_halt", 1, 1, 0, 16'h0000);
        check_eq("start_halt_run_lit", {31'd0, running}, 32'd0);
        cycle("restart", 1, 0, 0, 16'h0000);
        check_eq("restart_t_lit", {24'd0, t}, 32'h01);

        // Async reset mid-instruction at T5
        for (int k = 0; k < 5; k++) cycle("to_t5", 0, 0, 0, 16'hC000);
        check_eq("t5_lit", {24'd0, t}, 32'h20);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            cycle("rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 5) == 0), 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
